// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core, debug and memory-side signals of the data-memory arbiter
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          core_req, core_we, core_gnt, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we;
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core/debug arbiter for a single-port synchronous data memory
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_MAX = 8
) (
  input logic clk,
  input logic rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic {OPEN, LOCKED} state_t;
  state_t state, state_nx;
  logic [7:0] starve_cnt, starve_nx;
  logic sel, owner, core_g, dbg_g, rtag_valid, rtag_owner;
  logic [DW-1:0] core_hold, dbg_hold;
  logic [AW-1:0] addr_mux;
  always_comb begin
    dbg_g = ~rst & bus.dbg_req & (state == LOCKED | starve_cnt == 8'(STARVE_MAX) | ~bus.core_req);
    core_g = ~rst & bus.core_req & ~dbg_g;
    owner = (core_g | dbg_g) ? dbg_g : sel;
    addr_mux = owner ? bus.dbg_addr : bus.core_addr;
    starve_nx = (dbg_g | ~bus.dbg_req) ? 8'd0 : starve_cnt == 8'(STARVE_MAX) ? starve_cnt : starve_cnt + 8'd1;
    state_nx = state == OPEN ? (dbg_g & bus.dbg_lock ? LOCKED : OPEN)
                             : (~bus.dbg_req | dbg_g & ~bus.dbg_lock ? OPEN : LOCKED);
  end
  // outputs are forced to their reset values for as long as rst is held
  assign bus.core_gnt = core_g;
  assign bus.dbg_gnt = dbg_g;
  assign bus.mem_addr = rst ? {AW{1'b0}} : addr_mux;
  assign bus.mem_wdata = rst ? {DW{1'b0}} : owner ? bus.dbg_wdata : bus.core_wdata;
  assign bus.mem_we = dbg_g ? bus.dbg_we : core_g & bus.core_we;
  assign bus.core_rvalid = rtag_valid & ~rtag_owner;
  assign bus.dbg_rvalid = rtag_valid & rtag_owner;
  assign bus.core_rdata = bus.core_rvalid ? bus.mem_rdata : core_hold;
  assign bus.dbg_rdata = bus.dbg_rvalid ? bus.mem_rdata : dbg_hold;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= OPEN;
      starve_cnt <= 8'd0;
      sel <= 1'b0;
      rtag_valid <= 1'b0;
      rtag_owner <= 1'b0;
      core_hold <= {DW{1'b0}};
      dbg_hold <= {DW{1'b0}};
    end else begin
      state <= state_nx;
      starve_cnt <= starve_nx;
      sel <= owner;
      rtag_valid <= core_g & ~bus.core_we | dbg_g & ~bus.dbg_we;
      rtag_owner <= dbg_g;
      core_hold <= bus.core_rdata;
      dbg_hold <= bus.dbg_rdata;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random two-requester traffic against a decision-order reference model
module tb_dmem_arbiter;
  localparam int SM = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dmem_arbiter_if #(.AW(32), .DW(32)) bus();
  dmem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SM)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct {
    logic cg, dg, we, crv, drv;
    logic [31:0] addr, wdata, crd, drd;
    int cyc;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = -1, pc = 50, pd = 50;
  int pct [4] = '{0, 25, 60, 100};
  logic [31:0] ram [16] = '{default: '0};
  logic [31:0] ref_mem [16];
  logic m_locked, m_last_dbg, m_pv, m_pdbg, c_pend, d_pend;
  int m_wait;
  logic [31:0] m_pdata, m_hc, m_hd;
  function automatic logic [31:0] salt(int i);
    return 32'h9E3779B9 * 32'(i + 1);
  endfunction
  // behavioural memory: one-cycle read latency, write lands at the edge
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[5:2]] <= bus.mem_wdata ^ salt(int'(bus.mem_addr[5:2]));
    bus.mem_rdata <= ram[bus.mem_addr[5:2]] ^ salt(int'(bus.mem_addr[5:2]));
  end
  function automatic void chk(string n, logic [31:0] act, logic [31:0] req, int c);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", n, c, act, req);
    end
  endfunction
  always @(negedge clk)
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("core_gnt", 32'(bus.core_gnt), 32'(e.cg), e.cyc);
      chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(e.dg), e.cyc);
      chk("mem_we", 32'(bus.mem_we), 32'(e.we), e.cyc);
      chk("mem_addr", bus.mem_addr, e.addr, e.cyc);
      chk("mem_wdata", bus.mem_wdata, e.wdata, e.cyc);
      chk("core_rvalid", 32'(bus.core_rvalid), 32'(e.crv), e.cyc);
      chk("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(e.drv), e.cyc);
      chk("core_rdata", bus.core_rdata, e.crd, e.cyc);
      chk("dbg_rdata", bus.dbg_rdata, e.drd, e.cyc);
    end
  task automatic model_reset();
    m_locked = 1'b0; m_last_dbg = 1'b0; m_pv = 1'b0; m_pdbg = 1'b0;
    m_wait = 0; m_pdata = '0; m_hc = '0; m_hd = '0;
    c_pend = 1'b0; d_pend = 1'b0;
  endtask
  task automatic push_reset();
    exp_t e;
    e = '{default: '0};
    e.cyc = -1;
    sb.push_back(e);
  endtask
  task automatic gen(bit force_read);
    if (!c_pend) begin
      bus.core_req = $urandom_range(99) < pc;
      bus.core_we = 1'($urandom_range(1));
      bus.core_addr = $urandom;
      bus.core_wdata = $urandom;
    end
    if (!d_pend) begin
      bus.dbg_req = $urandom_range(99) < pd;
      bus.dbg_we = 1'($urandom_range(1));
      bus.dbg_addr = $urandom;
      bus.dbg_wdata = $urandom;
    end
    bus.dbg_lock = $urandom_range(99) < 60;
    if (force_read) begin
      bus.core_req = 1'b1;
      bus.core_we = 1'b0;
      bus.dbg_req = 1'b0;
    end
  endtask
  task automatic cycle_model();
    exp_t e;
    int win;
    if (bus.dbg_req && (m_locked || m_wait == SM)) win = 2;
    else if (bus.core_req) win = 1;
    else if (bus.dbg_req) win = 2;
    else win = 0;
    e.cyc = cyc;
    e.cg = win == 1;
    e.dg = win == 2;
    if (win != 0) m_last_dbg = win == 2;
    e.addr = m_last_dbg ? bus.dbg_addr : bus.core_addr;
    e.wdata = m_last_dbg ? bus.dbg_wdata : bus.core_wdata;
    e.we = win == 1 ? bus.core_we : win == 2 ? bus.dbg_we : 1'b0;
    e.crv = m_pv && !m_pdbg;
    e.drv = m_pv && m_pdbg;
    if (e.crv) m_hc = m_pdata;
    if (e.drv) m_hd = m_pdata;
    e.crd = m_hc;
    e.drd = m_hd;
    m_pv = win != 0 && !e.we;
    m_pdbg = win == 2;
    m_pdata = ref_mem[e.addr[5:2]];
    if (e.we) ref_mem[e.addr[5:2]] = e.wdata;
    if (win == 2) m_locked = bus.dbg_lock;
    else if (!bus.dbg_req) m_locked = 1'b0;
    m_wait = (win == 2 || !bus.dbg_req) ? 0 : (m_wait < SM ? m_wait + 1 : SM);
    c_pend = bus.core_req && win != 1;
    d_pend = bus.dbg_req && win != 2;
    sb.push_back(e);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = salt(i);
    model_reset();
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_lock = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      gen(1'b0);
      push_reset();
    end
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      if (n % 150 == 0) begin
        pc = pct[$urandom_range(3)];
        pd = pct[$urandom_range(3)];
      end
      cyc = n;
      gen(n % 700 == 350);
      cycle_model();
      // reset lands half a cycle after a granted core read, dropping it
      if (n % 700 == 350) begin
        @(negedge clk); #2;
        rst = 1'b1;
        model_reset();
      end
    end
    @(posedge clk); #1;
    bus.core_req = 1'b0;
    bus.dbg_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d records left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
